// File: rtl/inst_issue_pkg.sv
// Shared definitions for the instruction issue stage: word field positions,
// immediate/extension widths and the issue FSM state type.
// Build option: INST_ISSUE_HAZARD_EN adds the BUBBLE state used for
// read-after-write stalls between back-to-back instructions.
package inst_issue_pkg;

    // Instruction word layout
    localparam int IMMFLAG_BIT = 31;
    localparam int EXT_BIT     = 30;
    localparam int RD_MSB      = 29;
    localparam int RD_LSB      = 25;
    localparam int RS1_MSB     = 24;
    localparam int RS1_LSB     = 20;
    localparam int RS2_MSB     = 19;
    localparam int RS2_LSB     = 15;
    localparam int IMM15_MSB   = 14;

    // Immediate pieces: short immediate and the extension word appended above it
    localparam int IMM15_W     = 15;
    localparam int EXT_W       = 32;
    localparam int IMM_LONG_W  = IMM15_W + EXT_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXT    = 2'd1,
        ST_ISSUE  = 2'd2
`ifdef INST_ISSUE_HAZARD_EN
        ,
        ST_BUBBLE = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/inst_field_decode.sv
// Combinational field extraction for one instruction/extension word.
// Produces the register fields, the sign-extended short immediate, and the
// sign-extended long immediate formed from this word (as extension) placed
// above a previously captured imm15.
module inst_field_decode
    import inst_issue_pkg::*;
#(
    parameter int REG_WIDTH  = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int INST_WIDTH = 32
) (
    input  logic [INST_WIDTH-1:0] i_word,
    input  logic [IMM15_W-1:0]    i_pend_imm15,
    output logic                  o_immflag,
    output logic                  o_ext,
    output logic [ADDR_WIDTH-1:0] o_rd,
    output logic [ADDR_WIDTH-1:0] o_rs1,
    output logic [ADDR_WIDTH-1:0] o_rs2,
    output logic [IMM15_W-1:0]    o_imm15,
    output logic [REG_WIDTH-1:0]  o_imm_short,
    output logic [REG_WIDTH-1:0]  o_imm_long
);

    localparam int LONG_W = IMM15_W + INST_WIDTH;

    logic [LONG_W-1:0] w_long;

    // Slice the word into fields and build both sign-extended immediates
    always_comb begin
        o_immflag   = i_word[IMMFLAG_BIT];
        o_ext       = i_word[EXT_BIT];
        o_rd        = ADDR_WIDTH'(i_word[RD_MSB:RD_LSB]);
        o_rs1       = ADDR_WIDTH'(i_word[RS1_MSB:RS1_LSB]);
        o_rs2       = ADDR_WIDTH'(i_word[RS2_MSB:RS2_LSB]);
        o_imm15     = i_word[IMM15_MSB:0];
        o_imm_short = {{(REG_WIDTH-IMM15_W){i_word[IMM15_MSB]}}, i_word[IMM15_MSB:0]};
        w_long      = {i_word, i_pend_imm15};
        o_imm_long  = {{(REG_WIDTH-LONG_W){w_long[LONG_W-1]}}, w_long};
    end

endmodule

// File: rtl/inst_issue.sv
// Instruction issue stage: accepts one- or two-word instructions, assembles
// the immediate, and presents registered issue fields for exactly one cycle.
// Build option: INST_ISSUE_HAZARD_EN inserts a one-cycle BUBBLE when a
// back-to-back instruction reads the register the issuing one writes.
module inst_issue
    import inst_issue_pkg::*;
#(
    parameter int REG_WIDTH  = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_data,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] inst_rs1,
    output logic [ADDR_WIDTH-1:0] inst_rs2,
    output logic [ADDR_WIDTH-1:0] inst_rd,
    output logic                  inst_immflag,
    output logic [REG_WIDTH-1:0]  imm_data,
    output logic                  issue_valid,
    output logic                  busy
);

    state_t r_state;
    state_t w_state_nxt;

    // Registered outputs and their next values
    logic                  r_ready,     w_ready_nxt;
    logic                  r_busy,      w_busy_nxt;
    logic                  r_valid,     w_valid_nxt;
    logic [ADDR_WIDTH-1:0] r_rs1,       w_rs1_nxt;
    logic [ADDR_WIDTH-1:0] r_rs2,       w_rs2_nxt;
    logic [ADDR_WIDTH-1:0] r_rd,        w_rd_nxt;
    logic                  r_immflag,   w_immflag_nxt;
    logic [REG_WIDTH-1:0]  r_imm,       w_imm_nxt;

    // Fields of an instruction waiting for its extension word or a bubble
    logic                  r_pend_immflag, w_pend_immflag_nxt;
    logic [ADDR_WIDTH-1:0] r_pend_rs1,     w_pend_rs1_nxt;
    logic [ADDR_WIDTH-1:0] r_pend_rs2,     w_pend_rs2_nxt;
    logic [ADDR_WIDTH-1:0] r_pend_rd,      w_pend_rd_nxt;
    logic [IMM15_W-1:0]    r_pend_imm15,   w_pend_imm15_nxt;
`ifdef INST_ISSUE_HAZARD_EN
    logic [REG_WIDTH-1:0]  r_pend_imm,     w_pend_imm_nxt;
    logic                  w_hazard;
`endif

    // Decoded view of the incoming word
    logic                  w_dec_immflag;
    logic                  w_dec_ext;
    logic [ADDR_WIDTH-1:0] w_dec_rd;
    logic [ADDR_WIDTH-1:0] w_dec_rs1;
    logic [ADDR_WIDTH-1:0] w_dec_rs2;
    logic [IMM15_W-1:0]    w_dec_imm15;
    logic [REG_WIDTH-1:0]  w_dec_imm_short;
    logic [REG_WIDTH-1:0]  w_dec_imm_long;
    logic                  w_accept;

    inst_field_decode #(
        .REG_WIDTH  (REG_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_decode (
        .i_word       (in_data),
        .i_pend_imm15 (r_pend_imm15),
        .o_immflag    (w_dec_immflag),
        .o_ext        (w_dec_ext),
        .o_rd         (w_dec_rd),
        .o_rs1        (w_dec_rs1),
        .o_rs2        (w_dec_rs2),
        .o_imm15      (w_dec_imm15),
        .o_imm_short  (w_dec_imm_short),
        .o_imm_long   (w_dec_imm_long)
    );

    // flush blocks acceptance in the same cycle, so a coincident word is dropped
    assign in_ready     = r_ready & ~flush;
    assign w_accept     = in_valid & in_ready;
    assign issue_valid  = r_valid;
    assign inst_rs1     = r_rs1;
    assign inst_rs2     = r_rs2;
    assign inst_rd      = r_rd;
    assign inst_immflag = r_immflag;
    assign imm_data     = r_imm;
    assign busy         = r_busy;

`ifdef INST_ISSUE_HAZARD_EN
    // RAW check against the instruction issuing this cycle; rd=0 never stalls
    assign w_hazard = (r_state == ST_ISSUE) && (r_rd != {ADDR_WIDTH{1'b0}}) &&
                      ((w_dec_rs1 == r_rd) || (!w_dec_immflag && (w_dec_rs2 == r_rd)));
`endif

    // Next-state, next-output and pending-field selection
    always_comb begin
        w_state_nxt        = ST_IDLE;
        w_ready_nxt        = 1'b1;
        w_valid_nxt        = 1'b0;
        w_rs1_nxt          = {ADDR_WIDTH{1'b0}};
        w_rs2_nxt          = {ADDR_WIDTH{1'b0}};
        w_rd_nxt           = {ADDR_WIDTH{1'b0}};
        w_immflag_nxt      = 1'b0;
        w_imm_nxt          = {REG_WIDTH{1'b0}};
        w_pend_immflag_nxt = r_pend_immflag;
        w_pend_rs1_nxt     = r_pend_rs1;
        w_pend_rs2_nxt     = r_pend_rs2;
        w_pend_rd_nxt      = r_pend_rd;
        w_pend_imm15_nxt   = r_pend_imm15;
`ifdef INST_ISSUE_HAZARD_EN
        w_pend_imm_nxt     = r_pend_imm;
`endif
        if (flush) begin
            w_state_nxt        = ST_IDLE;
            w_pend_immflag_nxt = 1'b0;
            w_pend_rs1_nxt     = {ADDR_WIDTH{1'b0}};
            w_pend_rs2_nxt     = {ADDR_WIDTH{1'b0}};
            w_pend_rd_nxt      = {ADDR_WIDTH{1'b0}};
            w_pend_imm15_nxt   = {IMM15_W{1'b0}};
`ifdef INST_ISSUE_HAZARD_EN
            w_pend_imm_nxt     = {REG_WIDTH{1'b0}};
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_ISSUE: begin
                    if (w_accept && w_dec_ext) begin
                        w_state_nxt        = ST_EXT;
                        w_pend_immflag_nxt = w_dec_immflag;
                        w_pend_rs1_nxt     = w_dec_rs1;
                        w_pend_rs2_nxt     = w_dec_rs2;
                        w_pend_rd_nxt      = w_dec_rd;
                        w_pend_imm15_nxt   = w_dec_imm15;
                    end
`ifdef INST_ISSUE_HAZARD_EN
                    else if (w_accept && w_hazard) begin
                        w_state_nxt        = ST_BUBBLE;
                        w_ready_nxt        = 1'b0;
                        w_pend_immflag_nxt = w_dec_immflag;
                        w_pend_rs1_nxt     = w_dec_rs1;
                        w_pend_rs2_nxt     = w_dec_rs2;
                        w_pend_rd_nxt      = w_dec_rd;
                        w_pend_imm_nxt     = w_dec_imm_short;
                    end
`endif
                    else if (w_accept) begin
                        w_state_nxt   = ST_ISSUE;
                        w_valid_nxt   = 1'b1;
                        w_rs1_nxt     = w_dec_rs1;
                        w_rs2_nxt     = w_dec_rs2;
                        w_rd_nxt      = w_dec_rd;
                        w_immflag_nxt = w_dec_immflag;
                        w_imm_nxt     = w_dec_imm_short;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (w_accept) begin
                        w_state_nxt   = ST_ISSUE;
                        w_valid_nxt   = 1'b1;
                        w_rs1_nxt     = r_pend_rs1;
                        w_rs2_nxt     = r_pend_rs2;
                        w_rd_nxt      = r_pend_rd;
                        w_immflag_nxt = r_pend_immflag;
                        w_imm_nxt     = w_dec_imm_long;
                    end else begin
                        w_state_nxt = ST_EXT;
                    end
                end
`ifdef INST_ISSUE_HAZARD_EN
                ST_BUBBLE: begin
                    w_state_nxt   = ST_ISSUE;
                    w_valid_nxt   = 1'b1;
                    w_rs1_nxt     = r_pend_rs1;
                    w_rs2_nxt     = r_pend_rs2;
                    w_rd_nxt      = r_pend_rd;
                    w_immflag_nxt = r_pend_immflag;
                    w_imm_nxt     = r_pend_imm;
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, output and pending-field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_ready        <= 1'b1;
            r_busy         <= 1'b0;
            r_valid        <= 1'b0;
            r_rs1          <= {ADDR_WIDTH{1'b0}};
            r_rs2          <= {ADDR_WIDTH{1'b0}};
            r_rd           <= {ADDR_WIDTH{1'b0}};
            r_immflag      <= 1'b0;
            r_imm          <= {REG_WIDTH{1'b0}};
            r_pend_immflag <= 1'b0;
            r_pend_rs1     <= {ADDR_WIDTH{1'b0}};
            r_pend_rs2     <= {ADDR_WIDTH{1'b0}};
            r_pend_rd      <= {ADDR_WIDTH{1'b0}};
            r_pend_imm15   <= {IMM15_W{1'b0}};
`ifdef INST_ISSUE_HAZARD_EN
            r_pend_imm     <= {REG_WIDTH{1'b0}};
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_ready        <= w_ready_nxt;
            r_busy         <= w_busy_nxt;
            r_valid        <= w_valid_nxt;
            r_rs1          <= w_rs1_nxt;
            r_rs2          <= w_rs2_nxt;
            r_rd           <= w_rd_nxt;
            r_immflag      <= w_immflag_nxt;
            r_imm          <= w_imm_nxt;
            r_pend_immflag <= w_pend_immflag_nxt;
            r_pend_rs1     <= w_pend_rs1_nxt;
            r_pend_rs2     <= w_pend_rs2_nxt;
            r_pend_rd      <= w_pend_rd_nxt;
            r_pend_imm15   <= w_pend_imm15_nxt;
`ifdef INST_ISSUE_HAZARD_EN
            r_pend_imm     <= w_pend_imm_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_inst_issue.sv
// Scoreboard bench for inst_issue. The stimulus process runs an
// instruction-level reference model and queues each expected issue with the
// cycle it must appear in; a negedge monitor pops and compares.
module tb_inst_issue;

`ifdef INST_ISSUE_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        flush;
    logic [4:0]  inst_rs1, inst_rs2, inst_rd;
    logic        inst_immflag;
    logic [63:0] imm_data;
    logic        issue_valid;
    logic        busy;

    inst_issue #(.REG_WIDTH(64), .ADDR_WIDTH(5), .INST_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flush        (flush),
        .inst_rs1     (inst_rs1),
        .inst_rs2     (inst_rs2),
        .inst_rd      (inst_rd),
        .inst_immflag (inst_immflag),
        .imm_data     (imm_data),
        .issue_valid  (issue_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        immflag;
        logic [63:0] imm;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] mkw(input bit imf, input bit ext, input int rd,
                                        input int rs1, input int rs2, input int imm);
        return {imf, ext, 5'(rd), 5'(rs1), 5'(rs2), 15'(imm)};
    endfunction

    // Reference: fields by shifting, immediate by signed integer arithmetic
    function automatic exp_t make_exp(input logic [31:0] first, input logic [31:0] w, input bit is_ext);
        exp_t   e;
        longint v;
        e.due     = 0;
        e.immflag = (first >> 31) & 1;
        e.rd      = 5'((first >> 25) & 31);
        e.rs1     = 5'((first >> 20) & 31);
        e.rs2     = 5'((first >> 15) & 31);
        if (!is_ext) begin
            v = longint'(first & 32'h0000_7FFF);
            if (v >= 64'sd16384) v = v - 64'sd32768;
        end else begin
            v = longint'({32'd0, w}) * 64'sd32768 + longint'(first & 32'h0000_7FFF);
            if (v >= (64'sd1 <<< 46)) v = v - (64'sd1 <<< 47);
        end
        e.imm = 64'(v);
        return e;
    endfunction

    // Reference model state (instruction-level view)
    bit          m_ext_pend = 1'b0;
    logic [31:0] m_first    = 32'd0;
    bit          m_bub      = 1'b0;
    exp_t        m_bub_inst;
    bit          m_iss_now  = 1'b0;
    logic [4:0]  m_iss_rd   = 5'd0;

    // One cycle: drive, check handshake, advance the model, wait for the edge
    task automatic tick(input bit v, input logic [31:0] d, input bit f);
        bit         exp_ready;
        bit         exp_busy;
        bit         acc;
        bit         iss_nxt;
        logic [4:0] rd_nxt;
        exp_t       e;
        in_valid = v;
        in_data  = d;
        flush    = f;
        #1;
        exp_ready = !f && !m_bub;
        exp_busy  = m_iss_now || m_ext_pend || m_bub;
        chk("in_ready", 128'(in_ready), 128'(exp_ready));
        chk("busy", 128'(busy), 128'(exp_busy));
        acc     = v && exp_ready;
        iss_nxt = 1'b0;
        rd_nxt  = 5'd0;
        if (f) begin
            m_ext_pend = 1'b0;
            m_bub      = 1'b0;
        end else if (m_bub) begin
            e       = m_bub_inst;
            e.due   = cyc + 1;
            sbq.push_back(e);
            iss_nxt = 1'b1;
            rd_nxt  = e.rd;
            m_bub   = 1'b0;
        end else if (acc) begin
            if (m_ext_pend) begin
                e          = make_exp(m_first, d, 1'b1);
                e.due      = cyc + 1;
                sbq.push_back(e);
                iss_nxt    = 1'b1;
                rd_nxt     = e.rd;
                m_ext_pend = 1'b0;
            end else if (d[30]) begin
                m_ext_pend = 1'b1;
                m_first    = d;
            end else begin
                e = make_exp(d, 32'd0, 1'b0);
                if (HAZ && m_iss_now && (m_iss_rd != 5'd0) &&
                    ((e.rs1 == m_iss_rd) || (!e.immflag && (e.rs2 == m_iss_rd)))) begin
                    m_bub      = 1'b1;
                    m_bub_inst = e;
                end else begin
                    e.due   = cyc + 1;
                    sbq.push_back(e);
                    iss_nxt = 1'b1;
                    rd_nxt  = e.rd;
                end
            end
        end
        @(posedge clk);
        #1;
        m_iss_now = iss_nxt;
        m_iss_rd  = rd_nxt;
    endtask

    // Monitor: compare every issue against the queue; idle cycles must be all-zero
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (issue_valid) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_issue: got rd=%0d imm=%0h, expected no issue (cycle %0d)",
                             inst_rd, imm_data, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("issue_cycle", 128'(cyc), 128'(e.due));
                    chk("issue_fields", {48'd0, inst_rs1, inst_rs2, inst_rd, inst_immflag, imm_data},
                        {48'd0, e.rs1, e.rs2, e.rd, e.immflag, e.imm});
                end
            end else begin
                while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    n_vec++;
                    n_err++;
                    $display("FAIL missing_issue: got issue_valid=0, expected rd=%0d imm=%0h due %0d (cycle %0d)",
                             e.rd, e.imm, e.due, cyc);
                end
                chk("idle_zero", {48'd0, inst_rs1, inst_rs2, inst_rd, inst_immflag, imm_data}, 128'd0);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_issue_valid", 128'(issue_valid), 128'd0);
        chk("rst_fields", {48'd0, inst_rs1, inst_rs2, inst_rd, inst_immflag, imm_data}, 128'd0);

        // Single short instruction, then two idle cycles
        tick(1'b1, mkw(1, 0, 1, 0, 0, 10), 1'b0);
        repeat (2) tick(1'b0, 32'd0, 1'b0);

        // Two-word instructions, including a stall inside EXT
        tick(1'b1, mkw(0, 1, 2, 0, 0, 0), 1'b0);
        tick(1'b1, 32'hFFFF_FFFF, 1'b0);
        tick(1'b0, 32'd0, 1'b0);
        tick(1'b1, mkw(0, 1, 3, 0, 0, 32'h7FFF), 1'b0);
        tick(1'b0, 32'd0, 1'b0);
        tick(1'b1, 32'h0000_0001, 1'b0);
        repeat (2) tick(1'b0, 32'd0, 1'b0);

        // Three back-to-back short instructions
        tick(1'b1, mkw(0, 0, 5, 1, 2, 100), 1'b0);
        tick(1'b1, mkw(1, 0, 6, 3, 4, 32'h7FFB), 1'b0);
        tick(1'b1, mkw(0, 0, 7, 8, 9, 0), 1'b0);
        repeat (2) tick(1'b0, 32'd0, 1'b0);

        // Dependency on rd=3, then a dependency on rd=0
        tick(1'b1, mkw(0, 0, 3, 1, 2, 1), 1'b0);
        tick(1'b1, mkw(1, 0, 4, 3, 3, 2), 1'b0);
        tick(1'b1, mkw(0, 0, 0, 5, 6, 3), 1'b0);
        tick(1'b1, mkw(0, 0, 5, 0, 0, 4), 1'b0);
        repeat (3) tick(1'b0, 32'd0, 1'b0);

        // Flush during EXT, then flush coincident with a word in IDLE
        tick(1'b1, mkw(0, 1, 8, 1, 1, 7), 1'b0);
        tick(1'b0, 32'd0, 1'b1);
        tick(1'b0, 32'd0, 1'b0);
        tick(1'b1, mkw(0, 0, 9, 1, 1, 8), 1'b1);
        repeat (2) tick(1'b0, 32'd0, 1'b0);

        // Reset while in EXT
        tick(1'b1, mkw(1, 1, 10, 2, 2, 9), 1'b0);
        tick(1'b0, 32'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_issue_valid", 128'(issue_valid), 128'd0);
        chk("rstmid_busy", 128'(busy), 128'd0);
        sbq.delete();
        m_ext_pend = 1'b0;
        m_bub      = 1'b0;
        m_iss_now  = 1'b0;
        m_iss_rd   = 5'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rstrel_in_ready", 128'(in_ready), 128'd1);
        chk("rstrel_fields", {47'd0, issue_valid, inst_rs1, inst_rs2, inst_rd, inst_immflag, imm_data}, 128'd0);
        repeat (3) tick(1'b0, 32'd0, 1'b0);

        // Randomized traffic with small register indices to provoke dependencies
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            bit          v;
            bit          f;
            d        = $urandom;
            d[29:25] = 5'($urandom_range(0, 3));
            d[24:20] = 5'($urandom_range(0, 3));
            d[19:15] = 5'($urandom_range(0, 3));
            d[30]    = ($urandom_range(0, 3) == 0);
            v        = ($urandom_range(0, 99) < 70);
            f        = ($urandom_range(0, 99) < 5);
            tick(v, d, f);
        end

        repeat (5) tick(1'b0, 32'd0, 1'b0);
        chk("drain_empty", 128'(sbq.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_issue.md
INST_ISSUE -- requirements
Module: inst_issue

Interface
REQ-001 Parameter REG_WIDTH, default 64, width of imm_data.
REQ-002 Parameter ADDR_WIDTH, default 5, width of register address fields.
REQ-003 Parameter INST_WIDTH, default 32, width of instruction and extension words.
REQ-004 The clock SHALL be clk, single clock domain; reset is asynchronous and active-low, port rst_n.
REQ-005 Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  instruction or extension word present
- in_ready  out  1  word accepted on an edge where in_valid && in_ready
- in_data  in  INST_WIDTH  instruction or extension word
- flush  in  1  discard any partial or pending instruction
- inst_rs1  out  ADDR_WIDTH  source register 1 to regfile/ALU
- inst_rs2  out  ADDR_WIDTH  source register 2
- inst_rd  out  ADDR_WIDTH  destination register
- inst_immflag  out  1  ALU uses imm_data instead of rs2
- imm_data  out  REG_WIDTH  decoded immediate
- issue_valid  out  1  outputs form a valid instruction this cycle
- busy  out  1  state != IDLE

Function
REQ-006 Word format: [31] immflag, [30] ext, [29:25] rd, [24:20] rs1, [19:15] rs2, [14:0] imm15.
REQ-007 ext=0: imm_data SHALL equal imm15 sign-extended to REG_WIDTH.
REQ-008 ext=1: the next accepted word W SHALL be an extension; imm_data = {W, imm15} (47 bits) sign-extended to REG_WIDTH.
REQ-009 States: IDLE, EXT, ISSUE, BUBBLE; outputs registered.
REQ-010 Latency: issue_valid SHALL be 1 in the cycle after the edge accepting the last word of an instruction (ext=0 word, or W).
REQ-011 IDLE: in_ready=1; accept ext=0 -> ISSUE; accept ext=1 -> EXT; no accept -> IDLE.
REQ-012 EXT: in_ready=1; accept W -> ISSUE; otherwise hold EXT indefinitely.
REQ-013 ISSUE: issue_valid=1 for exactly this cycle; in_ready=1; accept ext=0 -> ISSUE with new fields (one instruction per cycle back-to-back); accept ext=1 -> EXT; no accept -> IDLE.
REQ-014 Whenever issue_valid=0, inst_rs1/rs2/rd/immflag/imm_data SHALL be driven to zero.
REQ-015 flush SHALL force in_ready=0 that cycle and state IDLE at the next edge; a coincident in_valid word is dropped, a pending EXT/BUBBLE instruction is discarded, no issue results.
REQ-016 BUBBLE: in_ready=0, issue_valid=0, pending fields held; next state ISSUE. Entered only per REQ-019.

Reset
REQ-017 rst_n low SHALL asynchronously force state IDLE, all outputs zero except in_ready=1 once rst_n is high, pending fields cleared.
REQ-018 Reset asserted mid-EXT or mid-BUBBLE SHALL discard the partial instruction; no issue after release without a new word.

Configuration
REQ-019 With INST_ISSUE_HAZARD_EN defined: an ext=0 word accepted in ISSUE whose rs1, or rs2 when its immflag=0, equals the currently issuing nonzero inst_rd SHALL go to BUBBLE for one cycle before issuing; without the macro no BUBBLE state exists and such words issue back-to-back.

Structure
REQ-020 Package inst_issue_pkg SHALL hold field bit positions, imm15/ext widths, and the state enum typedef.
REQ-021 One combinational sub-module inst_field_decode SHALL extract fields and sign-extend imm15; the FSM and output registers stay in inst_issue.

Verification
REQ-022 Reset: rst_n low while in EXT -> after release state IDLE, issue_valid=0, all fields 0, in_ready=1.
REQ-023 Word immflag=1, rd=1, imm15=10 accepted at edge N -> cycle N+1: issue_valid=1, inst_rd=1, inst_immflag=1, imm_data=10; cycle N+2 zeros.
REQ-024 ext=1, imm15=0, then W=0xFFFFFFFF -> imm_data=0xFFFF_FFFF_FFFF_8000; ext=1, imm15=0x7FFF, W=1 -> imm_data=0xFFFF; issue_valid only after W.
REQ-025 Three ext=0 words on consecutive edges -> issue_valid high three consecutive cycles, fields matching in order.
REQ-026 Macro defined: rd=3 then rs1=3 immflag=1 back-to-back -> one bubble cycle (issue_valid=0, in_ready=0) then issue; macro undefined -> no bubble; rd=0 never bubbles.
REQ-027 flush during EXT, and flush coincident with in_valid in IDLE -> state IDLE, no issue_valid, dropped word never issued.
